// File: rtl/serial_to_parallel_sync.sv
// serial_to_parallel_sync: hunts a comma symbol in a serial stream,
// locks after LOCK_COUNT aligned commas, then emits WIDTH-bit words.
module serial_to_parallel_sync #(
    parameter int unsigned      WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
    parameter int unsigned      LOCK_COUNT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID_OUT,
    output logic             COMMA_DET,
    output logic             LOCKED,
    output logic             ALIGN_ERR
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned NW = $clog2(LOCK_COUNT + 1);

    localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE = BW'(1);
    localparam logic [NW-1:0] LC      = NW'(LOCK_COUNT);
    localparam logic [NW-1:0] CNT_ONE = NW'(1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_ALIGN,
        ST_LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             det_q, det_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] win;
    logic             is_comma;
    logic             boundary;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [NW-1:0]    comma_cnt_inc;

    // Sliding window of the newest WIDTH bits and the per-cycle qualifiers.
    always_comb begin
        win           = {sr_q, DATA_IN};
        is_comma      = (win == COMMA);
        boundary      = (bit_cnt_q == LAST);
        bit_cnt_nxt   = boundary ? '0 : bit_cnt_q + BIT_ONE;
        comma_cnt_inc = (comma_cnt_q == LC) ? LC : comma_cnt_q + CNT_ONE;
    end

    // Next-state and registered-output logic for hunt / align / locked.
    always_comb begin
        state_d     = state_q;
        sr_d        = win[WIDTH-2:0];
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        det_d       = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = CNT_ONE;
                    if (LOCK_COUNT == 1) begin
                        state_d    = ST_LOCKED;
                        data_out_d = win;
                        valid_d    = 1'b1;
                        det_d      = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                if (boundary) begin
                    bit_cnt_d = bit_cnt_nxt;
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_inc;
                        if (comma_cnt_inc == LC) begin
                            state_d    = ST_LOCKED;
                            data_out_d = win;
                            valid_d    = 1'b1;
                            det_d      = 1'b1;
                        end
                    end else begin
                        state_d     = ST_HUNT;
                        comma_cnt_d = '0;
                        bit_cnt_d   = '0;
                    end
                end else if (is_comma) begin
                    // Comma on a new phase: restart from this boundary.
                    bit_cnt_d   = '0;
                    comma_cnt_d = CNT_ONE;
                end else begin
                    bit_cnt_d = bit_cnt_nxt;
                end
            end

            ST_LOCKED: begin
                if (boundary) begin
                    bit_cnt_d  = bit_cnt_nxt;
                    data_out_d = win;
                    valid_d    = 1'b1;
                    det_d      = is_comma;
                end else if (is_comma) begin
                    // Slipped comma: flag it and realign on it.
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    if (LOCK_COUNT != 1) begin
                        state_d     = ST_ALIGN;
                        comma_cnt_d = CNT_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_nxt;
                end
            end

            default: begin
                state_d     = ST_HUNT;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED) && !err_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            det_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            det_q       <= det_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign DATA_OUT  = data_out_q;
    assign VALID_OUT = valid_q;
    assign COMMA_DET = det_q;
    assign LOCKED    = locked_q;
    assign ALIGN_ERR = err_q;

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// tb_serial_to_parallel_sync: vector table, hand sequences and a
// randomized run against a phase-based reference model.
module tb_serial_to_parallel_sync;

    localparam logic [9:0] K  = 10'b0011111010;
    localparam logic [7:0] K8 = 8'hBC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic [9:0] dout;
    logic       vld, det, lk, err;

    logic       rst8 = 1'b1;
    logic       din8 = 1'b0;
    logic [7:0] dout8;
    logic       vld8, det8, lk8, err8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_to_parallel_sync dut (
        .CLK(clk), .RESET(rst), .DATA_IN(din),
        .DATA_OUT(dout), .VALID_OUT(vld), .COMMA_DET(det),
        .LOCKED(lk), .ALIGN_ERR(err)
    );

    serial_to_parallel_sync #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(2)
    ) dut8 (
        .CLK(clk), .RESET(rst8), .DATA_IN(din8),
        .DATA_OUT(dout8), .VALID_OUT(vld8), .COMMA_DET(det8),
        .LOCKED(lk8), .ALIGN_ERR(err8)
    );

    typedef struct {
        bit         rst;
        int         nb;
        logic [9:0] bits;
        int         nv;
        bit         ev;
        logic [9:0] ed;
        bit         edet;
        bit         elk;
        bit         eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, int nb, logic [9:0] b, int nv,
                                bit ev, logic [9:0] ed, bit edet,
                                bit elk, bit eerr);
        vec_t v;
        v.rst = r; v.nb = nb; v.bits = b; v.nv = nv;
        v.ev = ev; v.ed = ed; v.edet = edet; v.elk = elk; v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic b, input logic r);
        din = b;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic b, input logic r);
        din8 = b;
        rst8 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: alignment is an anchor time; boundaries are
    // every WIDTH cycles after it; the window is the last 10 bits seen.
    int         m_mode;
    int         m_anchor;
    int         m_cnt;
    int         m_t;
    bit         m_hist[$];
    logic [9:0] m_data;
    bit         m_v, m_det, m_lk, m_err;

    task automatic model_step(input bit b, input bit r);
        logic [9:0] w;
        bit         isc, bnd;
        m_v = 0; m_det = 0; m_err = 0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_t = 0; m_anchor = 0;
            m_hist.delete();
            m_data = '0; m_lk = 0;
            return;
        end
        m_t++;
        m_hist.push_back(b);
        if (m_hist.size() > 10) void'(m_hist.pop_front());
        w = '0;
        foreach (m_hist[i]) w = {w[8:0], m_hist[i]};
        isc = (w == K);
        bnd = (m_mode != 0) && (((m_t - m_anchor) % 10) == 0);
        case (m_mode)
            0: if (isc) begin
                m_anchor = m_t; m_cnt = 1; m_mode = 1;
            end
            1: if (bnd) begin
                if (isc) begin
                    m_cnt++;
                    if (m_cnt >= 4) begin
                        m_mode = 2; m_data = w; m_v = 1; m_det = 1;
                    end
                end else begin
                    m_mode = 0; m_cnt = 0;
                end
            end else if (isc) begin
                m_anchor = m_t; m_cnt = 1;
            end
            default: if (bnd) begin
                m_data = w; m_v = 1; m_det = isc;
            end else if (isc) begin
                m_err = 1; m_anchor = m_t; m_mode = 1; m_cnt = 1;
            end
        endcase
        m_lk = (m_mode == 2) && !m_err;
    endtask

    task automatic rnd_bit(input bit b, input bit r);
        step(b, r);
        model_step(b, r);
        n_checks++;
        if ({vld, det, lk, err, dout} !== {m_v, m_det, m_lk, m_err, m_data}) begin
            n_fail++;
            $display("FAIL rand t=%0d: got v%b d%b l%b e%b %h expected v%b d%b l%b e%b %h",
                     m_t, vld, det, lk, err, dout,
                     m_v, m_det, m_lk, m_err, m_data);
        end
    endtask

    initial begin
        int         nv, ne;
        logic [9:0] w;

        add(1, 2, 10'b10,  0, 0, 10'h000, 0, 0, 0);
        add(0, 3, 10'b000, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 1, 1, K,       1, 1, 0);
        add(0, 10, 10'h2AA, 1, 1, 10'h2AA, 0, 1, 0);
        add(0, 10, 10'h333, 1, 1, 10'h333, 0, 1, 0);
        add(0, 3, 10'b111, 0, 0, 10'h333, 0, 1, 0);
        add(0, 10, K, 1, 0, 10'h39F, 0, 0, 1);
        add(0, 10, K, 0, 0, 10'h39F, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h39F, 0, 0, 0);
        add(0, 10, K, 1, 1, K,       1, 1, 0);
        add(1, 2, 10'b01, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 0, 0, 10'h000, 0, 0, 0);
        add(0, 10, K, 1, 1, K,       1, 1, 0);
        add(0, 5, 10'b10101, 0, 0, K, 0, 1, 0);
        add(1, 1, 10'b1, 0, 0, 10'h000, 0, 0, 0);

        foreach (tbl[i]) begin
            nv = 0;
            ne = 0;
            for (int k = tbl[i].nb - 1; k >= 0; k--) begin
                step(tbl[i].bits[k], tbl[i].rst);
                if (vld === 1'b1) nv++;
                if (err === 1'b1) ne++;
            end
            check($sformatf("vec%0d pulses", i), {nv[15:0], ne[15:0]},
                  {tbl[i].nv[15:0], 15'd0, tbl[i].eerr});
            check($sformatf("vec%0d outputs", i),
                  {18'd0, vld, det, lk, err, dout},
                  {18'd0, tbl[i].ev, tbl[i].edet, tbl[i].elk,
                   tbl[i].eerr, tbl[i].ed});
        end

        step(1'b0, 1'b0);
        check("post reset idle", {27'd0, vld, lk, err, det}, 32'd0);

        step8(1'b1, 1'b1);
        w = {2'b00, K8};
        for (int k = 7; k >= 0; k--) step8(w[k], 1'b0);
        check("w8 first comma", {29'd0, lk8, vld8, err8}, 32'd0);
        for (int k = 7; k >= 0; k--) step8(w[k], 1'b0);
        check("w8 lock", {20'd0, lk8, vld8, det8, err8, dout8},
              {20'd0, 4'b1110, K8});
        w = 10'h055;
        nv = 0;
        for (int k = 7; k >= 0; k--) begin
            step8(w[k], 1'b0);
            if (vld8 === 1'b1) nv++;
        end
        check("w8 data", {20'd0, lk8, vld8, det8, err8, dout8},
              {20'd0, 4'b1100, 8'h55});
        check("w8 pulse count", nv, 1);
        rst8 = 1'b1;

        rnd_bit(1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 19);
            if (sel < 11) begin
                w = K;
                len = 10;
            end else if (sel < 16) begin
                w = 10'($urandom);
                len = 10;
            end else if (sel < 19) begin
                w = 10'($urandom);
                len = $urandom_range(1, 3);
            end else begin
                w = '0;
                len = 0;
                rnd_bit(1'b0, 1'b1);
            end
            for (int k = len - 1; k >= 0; k--) rnd_bit(w[k], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
